// File: rtl/fetch_stage.sv
// Instruction fetch stage: it computes the next PC, drives the instruction-memory
// request, and holds the IF/ID pipeline register. Stalls, redirects and memory
// wait states are handled here, along with a sticky misaligned-target flag and
// a saturating count of memory-wait bubbles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00400000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic [31:0]      i_cur_pc,
    output logic [31:0]      o_next_pc,
    output logic [31:0]      o_imem_addr,
    output logic             o_imem_req,
    input  logic             i_imem_ready,
    input  logic [31:0]      i_instr,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [31:0]      i_redirect_addr,
    output logic [31:0]      o_id_instr,
    output logic [31:0]      o_id_pc4,
    output logic             o_id_valid,
    output logic             o_addr_err,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    typedef enum logic {RUN, WAIT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        id_instr_q, id_instr_d;
    logic [31:0]        id_pc4_q, id_pc4_d;
    logic               id_valid_q, id_valid_d;
    logic               addr_err_q, addr_err_d;
    logic [CNT_W-1:0]   bubble_q, bubble_d;
    logic [31:0]        pc_plus4;

    assign pc_plus4     = i_cur_pc + 32'd4;
    assign o_imem_addr  = i_cur_pc;
    assign o_imem_req   = ~i_stall & ~i_arst;
    assign o_id_instr   = id_instr_q;
    assign o_id_pc4     = id_pc4_q;
    assign o_id_valid   = id_valid_q;
    assign o_addr_err   = addr_err_q;
    assign o_bubble_cnt = bubble_q;

    // Next-PC selection: a redirect wins, then stall/wait hold, else sequential.
    always_comb begin
        o_next_pc = pc_plus4;
        if (i_redirect) begin
            o_next_pc = {i_redirect_addr[31:2], 2'b00};
        end else if (i_stall || !i_imem_ready) begin
            o_next_pc = i_cur_pc;
        end
    end

    // FSM next state plus IF/ID, error-flag and bubble-counter next values.
    always_comb begin
        state_d    = state_q;
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        addr_err_d = addr_err_q;
        bubble_d   = bubble_q;

        case (state_q)
            RUN:     if (o_imem_req && !i_imem_ready) state_d = WAIT;
            WAIT:    if (i_imem_ready || i_redirect) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (i_redirect && (i_redirect_addr[1:0] != 2'b00)) begin
            addr_err_d = 1'b1;
        end

        if (i_redirect) begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
            id_pc4_d   = '0;
        end else if (i_stall) begin
            id_valid_d = id_valid_q;
        end else if (!i_imem_ready) begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
            if (bubble_q != '1) begin
                bubble_d = bubble_q + 1'b1;
            end
        end else begin
            id_instr_d = i_instr;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
        end
    end

    // State and IF/ID registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q    <= RUN;
            id_instr_q <= '0;
            id_pc4_q   <= RESET_PC;
            id_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            bubble_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= id_instr_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
            addr_err_q <= addr_err_d;
            bubble_q   <= bubble_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Expected values are hand-computed.
// A second instance with a 2-bit bubble counter covers counter saturation.
module tb_fetch_stage;

    logic        clk;
    logic        arst;
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        ready;
    logic [31:0] instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic        addr_err;
    logic [15:0] bubble_cnt;

    logic [31:0] s_next_pc, s_imem_addr, s_id_instr, s_id_pc4;
    logic        s_imem_req, s_id_valid, s_addr_err;
    logic [1:0]  s_bubble_cnt;

    int unsigned checks;
    int unsigned failures;

    fetch_stage #(.RESET_PC(32'h00400000), .CNT_W(16)) dut (
        .i_clk(clk), .i_arst(arst), .i_cur_pc(cur_pc), .o_next_pc(next_pc),
        .o_imem_addr(imem_addr), .o_imem_req(imem_req), .i_imem_ready(ready),
        .i_instr(instr), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_addr(redirect_addr), .o_id_instr(id_instr), .o_id_pc4(id_pc4),
        .o_id_valid(id_valid), .o_addr_err(addr_err), .o_bubble_cnt(bubble_cnt)
    );

    fetch_stage #(.RESET_PC(32'h00400000), .CNT_W(2)) dut_small (
        .i_clk(clk), .i_arst(arst), .i_cur_pc(cur_pc), .o_next_pc(s_next_pc),
        .o_imem_addr(s_imem_addr), .o_imem_req(s_imem_req), .i_imem_ready(ready),
        .i_instr(instr), .i_stall(stall), .i_redirect(redirect),
        .i_redirect_addr(redirect_addr), .o_id_instr(s_id_instr), .o_id_pc4(s_id_pc4),
        .o_id_valid(s_id_valid), .o_addr_err(s_addr_err), .o_bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        arst = 1'b1;
        cur_pc = 32'h00400000;
        ready = 1'b1;
        instr = '0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_addr = '0;

        #12;
        check_eq("rst_pc4", id_pc4, 32'h00400000);
        check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rst_instr", id_instr, 32'd0);
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_bubble", {16'd0, bubble_cnt}, 32'd0);
        check_eq("rst_err", {31'd0, addr_err}, 32'd0);
        arst = 1'b0;

        // Sequential stream A, B, C
        instr = 32'hAAAA0001;
        #1;
        check_eq("seq_req", {31'd0, imem_req}, 32'd1);
        check_eq("seq_addr", imem_addr, 32'h00400000);
        check_eq("seq_npc0", next_pc, 32'h00400004);
        step();
        check_eq("seq_A_instr", id_instr, 32'hAAAA0001);
        check_eq("seq_A_pc4", id_pc4, 32'h00400004);
        check_eq("seq_A_valid", {31'd0, id_valid}, 32'd1);
        cur_pc = 32'h00400004; instr = 32'hBBBB0002;
        #1 check_eq("seq_npc1", next_pc, 32'h00400008);
        step();
        check_eq("seq_B_instr", id_instr, 32'hBBBB0002);
        check_eq("seq_B_pc4", id_pc4, 32'h00400008);
        cur_pc = 32'h00400008; instr = 32'hCCCC0003;
        step();
        check_eq("seq_C_instr", id_instr, 32'hCCCC0003);
        check_eq("seq_C_pc4", id_pc4, 32'h0040000C);
        check_eq("seq_bubble", {16'd0, bubble_cnt}, 32'd0);

        // Memory wait for three cycles at 0x00400008
        ready = 1'b0; instr = 32'hDEADBEEF;
        #1 check_eq("wait_npc", next_pc, 32'h00400008);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("wait_valid", {31'd0, id_valid}, 32'd0);
            check_eq("wait_instr", id_instr, 32'd0);
            check_eq("wait_pc4_hold", id_pc4, 32'h0040000C);
            check_eq("wait_npc_hold", next_pc, 32'h00400008);
        end
        check_eq("wait_bubble3", {16'd0, bubble_cnt}, 32'd3);
        ready = 1'b1; instr = 32'hDDDD0004;
        #1 check_eq("wait_done_npc", next_pc, 32'h0040000C);
        step();
        check_eq("wait_D_instr", id_instr, 32'hDDDD0004);
        check_eq("wait_D_pc4", id_pc4, 32'h0040000C);
        check_eq("wait_D_valid", {31'd0, id_valid}, 32'd1);

        // Stall two cycles: IF/ID frozen, PC held, request dropped
        cur_pc = 32'h0040000C; instr = 32'hEEEE0005; stall = 1'b1;
        #1;
        check_eq("stall_npc", next_pc, 32'h0040000C);
        check_eq("stall_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("stall_instr", id_instr, 32'hDDDD0004);
            check_eq("stall_pc4", id_pc4, 32'h0040000C);
            check_eq("stall_valid", {31'd0, id_valid}, 32'd1);
        end
        stall = 1'b0;
        step();
        check_eq("stall_E_instr", id_instr, 32'hEEEE0005);
        check_eq("stall_E_pc4", id_pc4, 32'h00400010);
        cur_pc = 32'h00400010; instr = 32'hFFFF0006;
        step();
        check_eq("stall_F_instr", id_instr, 32'hFFFF0006);
        check_eq("stall_F_pc4", id_pc4, 32'h00400014);
        check_eq("stall_bubble", {16'd0, bubble_cnt}, 32'd3);

        // Redirect together with stall: redirect wins
        cur_pc = 32'h00400014; redirect = 1'b1; redirect_addr = 32'h00400100; stall = 1'b1;
        #1 check_eq("redir_npc", next_pc, 32'h00400100);
        step();
        check_eq("redir_valid", {31'd0, id_valid}, 32'd0);
        check_eq("redir_instr", id_instr, 32'd0);
        check_eq("redir_pc4", id_pc4, 32'd0);
        check_eq("redir_err0", {31'd0, addr_err}, 32'd0);
        stall = 1'b0; redirect_addr = 32'h00400102;
        #1 check_eq("mis_npc", next_pc, 32'h00400100);
        step();
        check_eq("mis_err", {31'd0, addr_err}, 32'd1);
        redirect = 1'b0; cur_pc = 32'h00400100; instr = 32'h11110007;
        step();
        check_eq("mis_err_sticky", {31'd0, addr_err}, 32'd1);
        check_eq("mis_G_instr", id_instr, 32'h11110007);
        check_eq("mis_G_pc4", id_pc4, 32'h00400104);

        // PC wrap at top of address space
        cur_pc = 32'hFFFFFFFC; instr = 32'h22220008;
        #1 check_eq("wrap_npc", next_pc, 32'd0);
        step();
        check_eq("wrap_pc4", id_pc4, 32'd0);
        check_eq("wrap_instr", id_instr, 32'h22220008);

        // Saturation: small counter already at 3 stays at 3
        cur_pc = 32'h00400200; ready = 1'b0;
        step();
        check_eq("sat_small", {30'd0, s_bubble_cnt}, 32'd3);
        check_eq("sat_big", {16'd0, bubble_cnt}, 32'd4);

        // Redirect while waiting: outstanding fetch abandoned even with ready
        ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h00400300; instr = 32'h33330009;
        #1 check_eq("wredir_npc", next_pc, 32'h00400300);
        step();
        check_eq("wredir_valid", {31'd0, id_valid}, 32'd0);
        check_eq("wredir_instr", id_instr, 32'd0);
        check_eq("wredir_bubble", {16'd0, bubble_cnt}, 32'd4);
        redirect = 1'b0; cur_pc = 32'h00400300; instr = 32'h4444000A;
        step();
        check_eq("wredir_next_instr", id_instr, 32'h4444000A);
        check_eq("wredir_next_pc4", id_pc4, 32'h00400304);

        // Asynchronous reset during WAIT
        ready = 1'b0; cur_pc = 32'h00400304;
        step();
        #2 arst = 1'b1;
        #1;
        check_eq("arst_pc4", id_pc4, 32'h00400000);
        check_eq("arst_valid", {31'd0, id_valid}, 32'd0);
        check_eq("arst_instr", id_instr, 32'd0);
        check_eq("arst_err", {31'd0, addr_err}, 32'd0);
        check_eq("arst_bubble", {16'd0, bubble_cnt}, 32'd0);
        check_eq("arst_req", {31'd0, imem_req}, 32'd0);
        #1 arst = 1'b0;
        cur_pc = 32'h00400000; ready = 1'b1; instr = 32'hAAAA0001;
        step();
        check_eq("post_rst_instr", id_instr, 32'hAAAA0001);
        check_eq("post_rst_pc4", id_pc4, 32'h00400004);
        check_eq("post_rst_valid", {31'd0, id_valid}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
